// File: rtl/shared_bus_arbiter_pkg.sv
// rtl/shared_bus_arbiter_pkg.sv - shared types and constants for the shared bus arbiter
package shared_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } arb_state_e;

    localparam logic [31:0] IDLE_VAL_DEFAULT = 32'h0;

endpackage

// File: rtl/shared_bus_arbiter_rr_pick.sv
// rtl/shared_bus_arbiter_rr_pick.sv - combinational round-robin priority picker
module rr_pick #(
    parameter int NREQ = 3,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx
);

    logic found;

    // Walk the agents starting at ptr, wrapping once; the first requester wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = int'(ptr) + i;
            if (k >= NREQ) begin
                k = k - NREQ;
            end
            if (!found && req[k]) begin
                found     = 1'b1;
                onehot[k] = 1'b1;
                idx       = IW'(k);
            end
        end
    end

endmodule

// File: rtl/shared_bus_arbiter.sv
// rtl/shared_bus_arbiter.sv - round-robin owner arbiter for a single aliased shared bus
module shared_bus_arbiter
    import shared_bus_arbiter_pkg::*;
#(
    parameter int               NREQ     = 3,
    parameter int               WIDTH    = 32,
    parameter int               MAX_HOLD = 8,
    parameter int               TURN_CYC = 1,
    parameter logic [WIDTH-1:0] IDLE_VAL = WIDTH'(IDLE_VAL_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       grant,
    output logic [WIDTH-1:0]      bus_data,
    output logic                  busy,
    output logic                  timeout
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TURN_CYC + 1);

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [TW-1:0]   turn_q, turn_d;
    logic            timeout_q, timeout_d;

    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   next_ptr;
    logic [WIDTH-1:0] bus_mux;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            turn_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            turn_q    <= turn_d;
            timeout_q <= timeout_d;
        end
    end

    // Priority restarts just past the releasing agent, so a timed-out owner goes to the back.
    assign next_ptr = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        turn_d    = turn_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_OWN;
                    grant_d = pick_onehot;
                    owner_d = pick_idx;
                    hold_d  = HW'(1);
                end
            end
            ST_OWN: begin
                if (!req[owner_q] || (hold_q == HW'(MAX_HOLD))) begin
                    state_d   = ST_TURN;
                    grant_d   = '0;
                    ptr_d     = next_ptr;
                    hold_d    = '0;
                    turn_d    = TW'(1);
                    timeout_d = req[owner_q];
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            ST_TURN: begin
                if (turn_q == TW'(TURN_CYC)) begin
                    state_d = ST_IDLE;
                    turn_d  = '0;
                end else begin
                    turn_d = turn_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        bus_mux = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                bus_mux = bus_mux | wdata[i*WIDTH +: WIDTH];
            end
        end
        busy     = !rst && (state_q != ST_IDLE);
        bus_data = (!rst && (state_q == ST_OWN)) ? bus_mux : IDLE_VAL;
        grant    = grant_q;
        timeout  = timeout_q;
    end

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// tb/tb_shared_bus_arbiter.sv - self-checking bench for shared_bus_arbiter
module tb_shared_bus_arbiter;

    localparam int N  = 3;
    localparam int W  = 32;
    localparam int MH = 8;
    localparam int TC = 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   grant;
    logic [W-1:0]   bus_data;
    logic           busy;
    logic           timeout;

    logic [0:0]     req1;
    logic [W-1:0]   wd1;
    logic [0:0]     grant1;
    logic [W-1:0]   bus1;
    logic           busy1;
    logic           to1;

    int n_cmp = 0;
    int n_bad = 0;
    bit run   = 1'b0;

    always #5 clk = ~clk;

    shared_bus_arbiter #(
        .NREQ(N), .WIDTH(W), .MAX_HOLD(MH), .TURN_CYC(TC), .IDLE_VAL(32'h0)
    ) u_dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata),
        .grant(grant), .bus_data(bus_data), .busy(busy), .timeout(timeout)
    );

    shared_bus_arbiter #(
        .NREQ(1), .WIDTH(W), .MAX_HOLD(2), .TURN_CYC(1), .IDLE_VAL(32'h0)
    ) u_one (
        .clk(clk), .rst(rst), .req(req1), .wdata(wd1),
        .grant(grant1), .bus_data(bus1), .busy(busy1), .timeout(to1)
    );

    // Model: who owns the bus, how long it has held it, and how many quiet cycles remain.
    int m_owner = -1;
    int m_held  = 0;
    int m_cool  = 0;
    int m_start = 0;
    bit m_to    = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1;
            m_held  = 0;
            m_cool  = 0;
            m_start = 0;
            m_to    = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_owner >= 0) begin
                if (!req[m_owner] || m_held == MH) begin
                    m_to    = req[m_owner];
                    m_start = (m_owner + 1) % N;
                    m_owner = -1;
                    m_cool  = TC;
                end else begin
                    m_held++;
                end
            end else if (m_cool > 0) begin
                m_cool--;
            end else if (req != 0) begin
                for (int i = 0; i < N; i++) begin
                    if (m_owner < 0 && req[(m_start + i) % N]) begin
                        m_owner = (m_start + i) % N;
                        m_held  = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            logic [N-1:0] e_grant;
            logic [W-1:0] e_bus;
            logic         e_busy;
            e_grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
            e_bus   = (!rst && m_owner >= 0) ? wdata[m_owner*W +: W] : '0;
            e_busy  = !rst && (m_owner >= 0 || m_cool > 0);
            n_cmp++;
            if (grant !== e_grant || bus_data !== e_bus || busy !== e_busy || timeout !== m_to) begin
                n_bad++;
                $display("FAIL model t=%0t: got grant=%b bus=%h busy=%b to=%b expected grant=%b bus=%h busy=%b to=%b",
                         $time, grant, bus_data, busy, timeout, e_grant, e_bus, e_busy, m_to);
            end
            n_cmp++;
            if ($countones(grant) > 1) begin
                n_bad++;
                $display("FAIL onehot t=%0t: got grant=%b expected at most one bit", $time, grant);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin
        rst   = 1'b1;
        req   = '0;
        wdata = {32'h3333_0003, 32'hdeadbeef, 32'h1111_0001};
        req1  = 1'b0;
        wd1   = 32'hcafe_f00d;
        step(2);
        run = 1'b1;
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_bus", bus_data, 32'h0);
        rst = 1'b0;

        for (int c = 0; c < 10; c++) begin
            step(1);
            chk("idle_grant", 32'(grant), 32'h0);
            chk("idle_busy", 32'(busy), 32'h0);
            chk("idle_bus", bus_data, 32'h0);
        end

        req = 3'b010;
        step(1);
        chk("single_grant", 32'(grant), 32'h2);
        chk("single_bus", bus_data, 32'hdeadbeef);
        chk("single_busy", 32'(busy), 32'h1);
        step(1);
        req = 3'b000;
        step(1);
        chk("single_turn_grant", 32'(grant), 32'h0);
        chk("single_turn_busy", 32'(busy), 32'h1);
        chk("single_turn_bus", bus_data, 32'h0);
        step(1);
        chk("single_idle_busy", 32'(busy), 32'h0);

        rst = 1'b1;
        step(1);
        rst = 1'b0;
        req = 3'b111;
        for (int a = 0; a < N; a++) begin
            for (int c = 0; c < 3; c++) begin
                step(1);
                chk("rr_grant", 32'(grant), 32'(1 << a));
            end
            req[a] = 1'b0;
            step(1);
            chk("rr_turn_grant", 32'(grant), 32'h0);
            chk("rr_turn_busy", 32'(busy), 32'h1);
            step(1);
            chk("rr_idle_busy", 32'(busy), 32'h0);
        end

        req = 3'b010;
        for (int c = 0; c < MH; c++) begin
            step(1);
            chk("volmax_grant", 32'(grant), 32'h2);
        end
        req = 3'b000;
        step(1);
        chk("volmax_timeout", 32'(timeout), 32'h0);
        chk("volmax_grant_off", 32'(grant), 32'h0);
        step(2);

        rst = 1'b1;
        step(1);
        rst = 1'b0;
        req = 3'b101;
        for (int c = 0; c < MH; c++) begin
            step(1);
            chk("to_hold_grant", 32'(grant), 32'h1);
        end
        step(1);
        chk("to_pulse", 32'(timeout), 32'h1);
        chk("to_turn_grant", 32'(grant), 32'h0);
        step(1);
        chk("to_pulse_end", 32'(timeout), 32'h0);
        for (int c = 0; c < 4; c++) begin
            step(1);
            chk("to_next_grant", 32'(grant), 32'h4);
            chk("to_next_bus", bus_data, 32'h3333_0003);
        end
        req = 3'b001;
        step(1);
        chk("to_vol_timeout", 32'(timeout), 32'h0);
        step(2);
        chk("to_regain_grant", 32'(grant), 32'h1);
        req = 3'b000;
        step(3);

        req = 3'b001;
        for (int c = 0; c < 4; c++) begin
            step(1);
            chk("rst_own_grant", 32'(grant), 32'h1);
        end
        rst = 1'b1;
        #1;
        chk("rst_own_busy", 32'(busy), 32'h0);
        chk("rst_own_bus", bus_data, 32'h0);
        step(1);
        chk("rst_drop_grant", 32'(grant), 32'h0);
        rst = 1'b0;
        req = 3'b011;
        step(1);
        chk("rst_winner", 32'(grant), 32'h1);
        chk("rst_winner_bus", bus_data, 32'h1111_0001);

        req = 3'b010;
        step(3);
        chk("glitch_pre_grant", 32'(grant), 32'h2);
        req = 3'b000;
        step(1);
        req = 3'b100;
        step(1);
        chk("glitch_idle_grant", 32'(grant), 32'h0);
        req = 3'b000;
        for (int c = 0; c < 4; c++) begin
            step(1);
            chk("glitch_grant", 32'(grant), 32'h0);
        end

        rst = 1'b1;
        step(1);
        rst  = 1'b0;
        req1 = 1'b1;
        step(1);
        chk("one_grant", 32'(grant1), 32'h1);
        chk("one_bus", bus1, 32'hcafe_f00d);
        step(1);
        chk("one_grant2", 32'(grant1), 32'h1);
        step(1);
        chk("one_timeout", 32'(to1), 32'h1);
        chk("one_turn_grant", 32'(grant1), 32'h0);
        step(1);
        chk("one_idle_busy", 32'(busy1), 32'h0);
        step(1);
        chk("one_regrant", 32'(grant1), 32'h1);
        req1 = 1'b0;
        step(3);

        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shared_bus_arbiter.md
SHARED_BUS_ARBITER -- requirements
Module: shared_bus_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3: number of agents sharing one aliased bus.
REQ-002 SHALL have parameter WIDTH, default 32: bus width in bits.
REQ-003 SHALL have parameter MAX_HOLD, default 8: maximum consecutive OWN cycles per grant, at least 1.
REQ-004 SHALL have parameter TURN_CYC, default 1: idle turnaround cycles between owners, at least 1.
REQ-005 SHALL have parameter IDLE_VAL, default 32'h0: value driven on the bus when no agent owns it.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port req, input, NREQ bits: per-agent bus request, level-held.
REQ-009 SHALL have port wdata, input, NREQ*WIDTH bits: per-agent drive data; agent i occupies bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port grant, output, NREQ bits: one-hot or zero registered ownership.
REQ-011 SHALL have port bus_data, output, WIDTH bits: resolved bus value.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 SHALL have port timeout, output, 1 bit: single-cycle pulse when a grant is force-released.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, OWN, TURN.
REQ-015 IDLE: grant=0; if any req bit is sampled high, SHALL select the winner and enter OWN, with grant asserted in the next cycle (1-cycle latency).
REQ-016 Selection SHALL be round-robin: search starts at index (last_owner+1) mod NREQ; after reset the search starts at index 0.
REQ-017 OWN: grant SHALL be one-hot for the owner, and bus_data SHALL equal the owner's wdata slice combinationally from the registered grant.
REQ-018 In all states other than OWN, bus_data SHALL equal IDLE_VAL.
REQ-019 hold_cnt SHALL count OWN cycles: it loads 1 on entry to OWN and increments each further OWN cycle, using a width of clog2(MAX_HOLD+1).
REQ-020 Voluntary release: when the owner's req is sampled low in OWN, the FSM SHALL enter TURN.
REQ-021 Forced release: when hold_cnt equals MAX_HOLD and req is still high, the FSM SHALL enter TURN and pulse timeout for that edge's cycle, so grant is held for exactly MAX_HOLD cycles.
REQ-022 Voluntary release on the same cycle hold_cnt reaches MAX_HOLD SHALL be treated as voluntary, with no timeout pulse.
REQ-023 On any release, last_owner SHALL be updated to the releasing agent, so a timed-out agent loses priority.
REQ-024 TURN: grant=0 for exactly TURN_CYC cycles, then the FSM SHALL enter IDLE; requests during TURN are not granted in TURN.
REQ-025 Requests withdrawn before being sampled in IDLE SHALL never be granted.
REQ-026 Requests from non-owners SHALL be ignored during OWN and TURN.
REQ-027 grant SHALL never have more than one bit set, in any cycle.
REQ-028 NREQ=1 SHALL work, with round-robin degenerating to a fixed grant.

Reset
REQ-029 On rst high at a clock edge, the block SHALL set state=IDLE, grant=0, hold_cnt=0, turn counter=0, timeout=0, and the pointer so that agent 0 has highest priority.
REQ-030 Reset mid-OWN or mid-TURN SHALL drop grant on the following cycle, and bus_data SHALL return to IDLE_VAL.
REQ-031 Outputs during reset SHALL be: busy=0, bus_data=IDLE_VAL.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (IDLE, OWN, TURN) and the default IDLE_VAL constant.
REQ-033 A single sub-module rr_pick SHALL be used: combinational round-robin priority picker with inputs req and pointer, and outputs one-hot and index.
REQ-034 Agents SHALL alias their ports to the bus; the arbiter is the only driver of bus_data.

Verification
REQ-035 Reset then idle: req=0 for 10 cycles -> grant=0, busy=0, bus_data=32'h0 throughout.
REQ-036 Single requester: req=3'b010, wdata[1]=32'hdeadbeef -> grant=3'b010 one cycle later and bus_data=32'hdeadbeef; req dropped -> TURN for 1 cycle, then IDLE.
REQ-037 All three request together after reset, each holding 3 cycles -> grants in order 001, 010, 100, each lasting 3 cycles, with a 1-cycle TURN plus 1-cycle IDLE gap between grants.
REQ-038 Timeout: agent 0 holds req 20 cycles with agent 2 also requesting -> grant 001 for exactly 8 cycles, timeout pulse, then 100 granted; agent 0 regains the bus only after agent 2 releases.
REQ-039 Reset mid-OWN: rst pulsed on the 4th OWN cycle -> grant=0 next cycle; after rst deasserts with req=3'b011, agent 0 wins.
REQ-040 Glitch request: req[2] high only during TURN -> never granted; one-hot grant assertion checked every cycle.
